// File: rtl/fp_align_add.sv
// Single-precision adder front end: unpack, swap, iterative align with sticky,
// then mantissa add/subtract. Produces the {ES, MS, CO} triple for the normaliser.
module fp_align_add #(
  parameter int ALIGN_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic        out_special,
  output logic        CO,
  output logic [7:0]  ES,
  output logic [27:0] MS
);

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, DONE} state_t;

  localparam logic [7:0]  STEP = 8'(ALIGN_STEP);
  localparam logic [27:0] QNAN = 28'h4000000;

  state_t      state;
  logic [31:0] ra, rb;
  logic        rop;
  logic [27:0] mx, my;
  logic [7:0]  ex, rem;
  logic        sx, sy;
  logic        spec, spec_nan, spec_sign;

  // unpack / swap / special detection, consumed in UNPACK
  logic [7:0]  ea_raw, eb_raw, ea, eb, d;
  logic [27:0] ma, mb;
  logic        sa, sb, a_big;
  logic        a_x, b_x, a_nan, b_nan, a_inf, b_inf;

  always_comb begin
    ea_raw = ra[30:23];
    eb_raw = rb[30:23];
    ea     = (ea_raw == 8'd0) ? 8'd1 : ea_raw;
    eb     = (eb_raw == 8'd0) ? 8'd1 : eb_raw;
    ma     = {ea_raw != 8'd0, ra[22:0], 4'b0};
    mb     = {eb_raw != 8'd0, rb[22:0], 4'b0};
    sa     = ra[31];
    sb     = rb[31] ^ rop;
    a_big  = ra[30:0] >= rb[30:0];
    d      = a_big ? (ea - eb) : (eb - ea);
    a_x    = ea_raw == 8'hFF;
    b_x    = eb_raw == 8'hFF;
    a_nan  = a_x && (ra[22:0] != 23'd0);
    b_nan  = b_x && (rb[22:0] != 23'd0);
    a_inf  = a_x && !a_nan;
    b_inf  = b_x && !b_nan;
  end

  // one alignment step; every bit shifted out folds into bit 0
  logic [7:0]  sh, rem_nxt;
  logic [27:0] mask, my_nxt;

  always_comb begin
    sh      = (rem > STEP) ? STEP : rem;
    mask    = (28'd1 << sh) - 28'd1;
    my_nxt  = (my >> sh) | {27'b0, |(my & mask)};
    rem_nxt = rem - sh;
    if (rem >= 8'd28) begin
      my_nxt  = {27'b0, |my};
      rem_nxt = 8'd0;
    end
  end

  logic [28:0] sum;
  logic [27:0] diff;
  logic        eff_sub;

  always_comb begin
    eff_sub = sx ^ sy;
    sum     = {1'b0, mx} + {1'b0, my};
    diff    = mx - my;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_sign    <= 1'b0;
      out_special <= 1'b0;
      CO          <= 1'b0;
      ES          <= 8'd0;
      MS          <= 28'd0;
      ra          <= 32'd0;
      rb          <= 32'd0;
      rop         <= 1'b0;
      mx          <= 28'd0;
      my          <= 28'd0;
      ex          <= 8'd0;
      rem         <= 8'd0;
      sx          <= 1'b0;
      sy          <= 1'b0;
      spec        <= 1'b0;
      spec_nan    <= 1'b0;
      spec_sign   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ra       <= a;
          rb       <= b;
          rop      <= op;
          in_ready <= 1'b0;
          state    <= UNPACK;
        end
        UNPACK: begin
          mx        <= a_big ? ma : mb;
          my        <= a_big ? mb : ma;
          ex        <= a_big ? ea : eb;
          sx        <= a_big ? sa : sb;
          sy        <= a_big ? sb : sa;
          rem       <= d;
          spec      <= a_x || b_x;
          spec_nan  <= a_nan || b_nan || (a_inf && b_inf && (sa != sb));
          spec_sign <= a_inf ? sa : sb;
          state     <= (a_x || b_x || d == 8'd0) ? ADD : ALIGN;
        end
        ALIGN: begin
          my    <= my_nxt;
          rem   <= rem_nxt;
          if (rem_nxt == 8'd0) state <= ADD;
        end
        ADD: begin
          out_valid   <= 1'b1;
          out_special <= spec;
          state       <= DONE;
          if (spec) begin
            ES       <= 8'hFF;
            CO       <= 1'b0;
            MS       <= spec_nan ? QNAN : 28'd0;
            out_sign <= spec_nan ? 1'b0 : spec_sign;
          end else if (eff_sub) begin
            ES       <= ex;
            CO       <= 1'b0;
            MS       <= diff;
            out_sign <= (diff == 28'd0) ? 1'b0 : sx;
          end else begin
            ES       <= ex;
            {CO, MS} <= sum;
            out_sign <= sx;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_align_add.sv
// Directed bench for fp_align_add with ALIGN_STEP=4: results, latency, hold and reset abort.
module tb_fp_align_add;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, op, out_valid, out_ready;
  logic        out_sign, out_special, CO;
  logic [31:0] a, b;
  logic [7:0]  ES;
  logic [27:0] MS;

  int checks = 0;
  int errors = 0;

  fp_align_add #(.ALIGN_STEP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_special(out_special), .CO(CO), .ES(ES), .MS(MS)
  );

  always #5 clk = ~clk;

  // result bundle: {special, sign, CO, ES, MS}
  function automatic logic [38:0] res();
    return {out_special, out_sign, CO, ES, MS};
  endfunction

  // drive one operation; lat counts cycles with the accepting cycle as 1, -1 on timeout
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic top,
                       output int lat);
    int n;
    a = ta; b = tb; op = top; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_hs: valid=%b ready=%b expected 0 1", out_valid, in_ready);
    end
    checks++;
    if (res() !== 39'd0) begin
      errors++; $display("FAIL reset_out: got %h expected 0", res());
    end
  endtask

  task automatic test_equal_exp();
    int lat;
    do_op(32'h3F800000, 32'h3F800000, 1'b0, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL add_1p1_lat: got %0d expected 3", lat); end
    checks++;
    if (res() !== {3'b001, 8'h7F, 28'h0}) begin
      errors++; $display("FAIL add_1p1: got %h expected %h", res(), {3'b001, 8'h7F, 28'h0});
    end
    release_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL release: ready=%b valid=%b expected 1 0", in_ready, out_valid);
    end
    do_op(32'h3F800000, 32'h3F800000, 1'b1, lat);
    checks++;
    if (lat !== 3 || res() !== {3'b000, 8'h7F, 28'h0}) begin
      errors++; $display("FAIL sub_1m1: got %h lat %0d expected %h lat 3", res(), lat, {3'b000, 8'h7F, 28'h0});
    end
    release_out();
    // exact cancellation through a negative b with op=add
    do_op(32'h3F800000, 32'hBF800000, 1'b0, lat);
    checks++;
    if (res() !== {3'b000, 8'h7F, 28'h0}) begin
      errors++; $display("FAIL cancel: got %h expected %h", res(), {3'b000, 8'h7F, 28'h0});
    end
    release_out();
    // min normal + denormal: denormal has hidden 0 and effective exponent 1
    do_op(32'h00800000, 32'h00400000, 1'b0, lat);
    checks++;
    if (lat !== 3 || res() !== {3'b000, 8'h01, 28'hC000000}) begin
      errors++; $display("FAIL denorm: got %h lat %0d expected %h lat 3", res(), lat, {3'b000, 8'h01, 28'hC000000});
    end
    release_out();
  endtask

  task automatic test_align();
    int lat;
    do_op(32'h40000000, 32'h3F800000, 1'b0, lat);
    checks++;
    if (lat !== 4 || res() !== {3'b000, 8'h80, 28'hC000000}) begin
      errors++; $display("FAIL align_d1: got %h lat %0d expected %h lat 4", res(), lat, {3'b000, 8'h80, 28'hC000000});
    end
    release_out();
    // 1 - 2: swap puts b first, result sign follows the negated b
    do_op(32'h3F800000, 32'h40000000, 1'b1, lat);
    checks++;
    if (lat !== 4 || res() !== {3'b010, 8'h80, 28'h4000000}) begin
      errors++; $display("FAIL swap_sub: got %h lat %0d expected %h lat 4", res(), lat, {3'b010, 8'h80, 28'h4000000});
    end
    release_out();
    // d=5: two cycles (4 then 1); lsb of b lands in sticky
    do_op(32'h3F800000, 32'h3D000001, 1'b0, lat);
    checks++;
    if (lat !== 5 || res() !== {3'b000, 8'h7F, 28'h8400001}) begin
      errors++; $display("FAIL sticky_d5: got %h lat %0d expected %h lat 5", res(), lat, {3'b000, 8'h7F, 28'h8400001});
    end
    release_out();
    // d=27: last iterative case, seven cycles
    do_op(32'h3F800000, 32'h32000000, 1'b0, lat);
    checks++;
    if (lat !== 10 || res() !== {3'b000, 8'h7F, 28'h8000001}) begin
      errors++; $display("FAIL align_d27: got %h lat %0d expected %h lat 10", res(), lat, {3'b000, 8'h7F, 28'h8000001});
    end
    release_out();
    // d=28 and d=30 collapse in one cycle
    do_op(32'h3F800000, 32'h31800000, 1'b0, lat);
    checks++;
    if (lat !== 4 || res() !== {3'b000, 8'h7F, 28'h8000001}) begin
      errors++; $display("FAIL align_d28: got %h lat %0d expected %h lat 4", res(), lat, {3'b000, 8'h7F, 28'h8000001});
    end
    release_out();
    do_op(32'h3F800000, 32'h30800000, 1'b0, lat);
    checks++;
    if (lat !== 4 || res() !== {3'b000, 8'h7F, 28'h8000001}) begin
      errors++; $display("FAIL align_d30: got %h lat %0d expected %h lat 4", res(), lat, {3'b000, 8'h7F, 28'h8000001});
    end
    release_out();
  endtask

  task automatic test_special();
    int lat;
    do_op(32'h7FC00000, 32'h3F800000, 1'b0, lat);
    checks++;
    if (lat !== 3 || res() !== {3'b100, 8'hFF, 28'h4000000}) begin
      errors++; $display("FAIL nan: got %h lat %0d expected %h lat 3", res(), lat, {3'b100, 8'hFF, 28'h4000000});
    end
    release_out();
    do_op(32'h7F800000, 32'h7F800000, 1'b1, lat);
    checks++;
    if (res() !== {3'b100, 8'hFF, 28'h4000000}) begin
      errors++; $display("FAIL inf_m_inf: got %h expected %h", res(), {3'b100, 8'hFF, 28'h4000000});
    end
    release_out();
    do_op(32'h3F800000, 32'h7F800000, 1'b1, lat);
    checks++;
    if (res() !== {3'b110, 8'hFF, 28'h0}) begin
      errors++; $display("FAIL one_m_inf: got %h expected %h", res(), {3'b110, 8'hFF, 28'h0});
    end
    release_out();
    do_op(32'h7F800000, 32'h3F800000, 1'b0, lat);
    checks++;
    if (res() !== {3'b100, 8'hFF, 28'h0}) begin
      errors++; $display("FAIL inf_p_one: got %h expected %h", res(), {3'b100, 8'hFF, 28'h0});
    end
    release_out();
  endtask

  task automatic test_hold_and_abort();
    int lat;
    do_op(32'h40000000, 32'h3F800000, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (res() !== {3'b000, 8'h80, 28'hC000000} || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_%0d: got %h valid=%b ready=%b", i, res(), out_valid, in_ready);
      end
    end
    release_out();
    // start a d=27 op and reset while it is aligning
    a = 32'h3F800000; b = 32'h32000000; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || res() !== 39'd0) begin
      errors++; $display("FAIL abort: valid=%b ready=%b out=%h expected 0 1 0", out_valid, in_ready, res());
    end
    // block is usable again after the abort
    do_op(32'h3F800000, 32'h3F800000, 1'b0, lat);
    checks++;
    if (lat !== 3 || res() !== {3'b001, 8'h7F, 28'h0}) begin
      errors++; $display("FAIL post_abort: got %h lat %0d expected %h lat 3", res(), lat, {3'b001, 8'h7F, 28'h0});
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_equal_exp();
    test_align();
    test_special();
    test_hold_and_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
